riscv_aes_wb_queue: RTL and testbench
=====================================

Name: riscv_aes_wb_queue

Overview:
Parametrised next-generation AES write-back stage. It sits between riscv_aes_cipher and the core data-memory port. Each ciphered block and its destination address are accepted into a DEPTH-entry FIFO. Each block is then serialised into BUS_WIDTH-wide memory writes with a valid/grant handshake. halt_en_out stalls the core while any write-back is outstanding.

Parameters:
BLOCK_WIDTH, 128, ciphered block width in bits; must be an integer multiple of BUS_WIDTH.
BUS_WIDTH, 32, memory write data width.
ADDR_WIDTH, 32, address width.
DEPTH, 4, FIFO entries; power of two, at least 2.
ADDR_STRIDE, 4, byte increment between consecutive words of one block.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start_aes_wb  in  1  block valid from cipher; a single-cycle pulse per block.
address_in  in  ADDR_WIDTH  base byte address of the block.
data_in  in  BLOCK_WIDTH  ciphered block.
in_ready_o  out  1  FIFO can accept a block this cycle.
write_en_out  out  1  memory write request valid.
write_gnt_i  in  1  memory accepted the current word.
address_out  out  ADDR_WIDTH  write address.
data_out  out  BUS_WIDTH  write data.
halt_en_out  out  1  core stall request.
busy_o  out  1  serialiser not idle.
overflow_o  out  1  sticky flag: a block was dropped.
fill_o  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- The block has one clock, clk, and one reset, rst_n, which is asynchronous and active-low.
- Reset values: write_en_out=0, address_out=0, data_out=0, halt_en_out=0, busy_o=0, overflow_o=0, fill_o=0, in_ready_o=1. The FIFO is emptied and the FSM goes to IDLE. Reset mid-block abandons the block; no further writes occur for it.
- NW = BLOCK_WIDTH/BUS_WIDTH words per block.
- Word k (k=0..NW-1) is data_in[BLOCK_WIDTH-1-k*BUS_WIDTH -: BUS_WIDTH], so the MSB word goes first.
- Word k is written to address_in + k*ADDR_STRIDE, computed modulo 2^ADDR_WIDTH; wrap-around is silent.
- in_ready_o = (fill < DEPTH) or (a pop occurs this cycle).
- Push: on a clk edge with start_aes_wb=1 and in_ready_o=1, {address_in, data_in} is written at the tail.
- Push while full with no pop: the block is dropped and overflow_o is set. overflow_o clears only on reset.
- Simultaneous push and pop when full is accepted; fill is unchanged.
- FSM has two states, IDLE and WRITE:
  - IDLE: when fill>0, pop the head into the shift register, load address_out, set word index to 0, go to WRITE.
  - WRITE: write_en_out=1; data_out and address_out stay stable until granted.
  - On write_gnt_i=1 with index<NW-1: shift to the next word, add ADDR_STRIDE to address_out, increment index.
  - On write_gnt_i=1 with index=NW-1: if fill>0, pop the next entry and stay in WRITE, so blocks go out back to back with no bubble. Otherwise go to IDLE and deassert write_en_out.
- Latency: a push at edge N into an empty, idle queue gives write_en_out=1 during cycle N+1 to N+2, i.e. after edge N+1. With grant tied high, one word is written per cycle, so a block takes NW cycles.
- busy_o = (state==WRITE).
- halt_en_out = busy_o or (fill>0) or start_aes_wb. It is combinational on start_aes_wb so the core stalls from the first cycle.
- write_gnt_i is ignored when write_en_out=0.
- fill_o tracks occupancy exactly.
- Pointers wrap modulo DEPTH.

Test Plan:
1. Single block, grant tied high: push data_in={deadbeef,deafbabe,cafeface,01234567}, address_in=0x1000. Expect 4 consecutive writes: (0x1000,deadbeef), (0x1004,deafbabe), (0x1008,cafeface), (0x100C,01234567). The first write appears one cycle after the push edge. halt_en_out is high from the push cycle through the last grant, then low.
2. Backpressure: same block, write_gnt_i high only every third cycle. address_out and data_out hold stable between grants, and exactly 4 writes occur in order.
3. Back-to-back: push blocks A@0x2000 and B@0x3000 on consecutive cycles, grant high. Expect 8 contiguous write_en_out cycles, B word0 at 0x3000 immediately after A word3, and fill_o peaking at 1.
4. Overflow: DEPTH=4 with grant low; push 6 blocks. The first is loaded into the serialiser, the next 4 fill the FIFO (fill_o=4, in_ready_o=0), and the 6th is dropped with overflow_o=1. Release grant and expect exactly 20 writes; overflow_o stays 1.
5. Address wrap: address_in=0xFFFFFFF8. Expect writes at FFFFFFF8, FFFFFFFC, 00000000, 00000004.
6. Reset mid-block: assert rst_n=0 after 2 of 4 grants. All outputs go to reset values immediately (asynchronously), no further writes occur after release, and fill_o=0.

Source files
------------

// File: rtl/riscv_aes_wb_queue.sv
// AES write-back queue: buffers ciphered blocks with their base address and
// serialises each block into bus-width memory writes, MSB word first.
//
// state   | meaning
// S_IDLE  | serialiser empty, waiting for a queued block
// S_WRITE | presenting words of the current block to memory
module riscv_aes_wb_queue #(
  parameter int BLOCK_WIDTH = 128,
  parameter int BUS_WIDTH   = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 4,
  parameter int ADDR_STRIDE = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_aes_wb,
  input  logic [ADDR_WIDTH-1:0]      address_in,
  input  logic [BLOCK_WIDTH-1:0]     data_in,
  output logic                       in_ready_o,
  output logic                       write_en_out,
  input  logic                       write_gnt_i,
  output logic [ADDR_WIDTH-1:0]      address_out,
  output logic [BUS_WIDTH-1:0]       data_out,
  output logic                       halt_en_out,
  output logic                       busy_o,
  output logic                       overflow_o,
  output logic [$clog2(DEPTH):0]     fill_o
);

  localparam int NW     = BLOCK_WIDTH / BUS_WIDTH;
  localparam int IDX_W  = (NW > 1) ? $clog2(NW) : 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;

  typedef enum logic {S_IDLE, S_WRITE} state_e;

  state_e                  state_q, state_d;
  logic [FILL_W-1:0]       fill_q;
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic                    overflow_q;
  logic [BLOCK_WIDTH-1:0]  sh_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [IDX_W-1:0]        idx_q;

  logic [ADDR_WIDTH-1:0]   addr_mem [DEPTH];
  logic [BLOCK_WIDTH-1:0]  data_mem [DEPTH];

  logic pop, shift, push, last_word, fifo_full;

  assign last_word = (idx_q == IDX_W'(NW - 1));
  assign fifo_full = (fill_q == FILL_W'(DEPTH));

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    shift   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fill_q != '0) begin
          pop     = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (write_gnt_i) begin
          if (!last_word) begin
            shift = 1'b1;
          end else if (fill_q != '0) begin
            // chain straight into the next block, no idle bubble
            pop = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready_o   = !fifo_full || pop;
  assign push         = start_aes_wb && in_ready_o;
  assign busy_o       = (state_q == S_WRITE);
  assign write_en_out = busy_o;
  assign halt_en_out  = busy_o || (fill_q != '0) || start_aes_wb;
  assign address_out  = addr_q;
  assign data_out     = sh_q[BLOCK_WIDTH-1 -: BUS_WIDTH];
  assign overflow_o   = overflow_q;
  assign fill_o       = fill_q;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= address_in;
      data_mem[wr_ptr_q] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fill_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      sh_q       <= '0;
      addr_q     <= '0;
      idx_q      <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      fill_q <= fill_q + FILL_W'(1);
      else if (pop && !push) fill_q <= fill_q - FILL_W'(1);
      if (start_aes_wb && !in_ready_o) overflow_q <= 1'b1;
      if (pop) begin
        sh_q   <= data_mem[rd_ptr_q];
        addr_q <= addr_mem[rd_ptr_q];
        idx_q  <= '0;
      end else if (shift) begin
        sh_q   <= sh_q << BUS_WIDTH;
        addr_q <= addr_q + ADDR_WIDTH'(ADDR_STRIDE);
        idx_q  <= idx_q + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_riscv_aes_wb_queue.sv
// Bench for riscv_aes_wb_queue: directed scenarios plus random traffic checked
// against a word-stream / occupancy reference model.
module tb_riscv_aes_wb_queue;

  localparam int NW    = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_aes_wb;
  logic [31:0]   address_in;
  logic [127:0]  data_in;
  logic          in_ready_o;
  logic          write_en_out;
  logic          write_gnt_i;
  logic [31:0]   address_out;
  logic [31:0]   data_out;
  logic          halt_en_out;
  logic          busy_o;
  logic          overflow_o;
  logic [2:0]    fill_o;

  riscv_aes_wb_queue dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_aes_wb (start_aes_wb),
    .address_in   (address_in),
    .data_in      (data_in),
    .in_ready_o   (in_ready_o),
    .write_en_out (write_en_out),
    .write_gnt_i  (write_gnt_i),
    .address_out  (address_out),
    .data_out     (data_out),
    .halt_en_out  (halt_en_out),
    .busy_o       (busy_o),
    .overflow_o   (overflow_o),
    .fill_o       (fill_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_writes = 0;

  // reference model: expected word stream plus block/word occupancy
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  int  m_fill = 0;
  int  m_wl   = 0;
  bit  m_ovf  = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // one clock cycle; entered and left at a falling edge
  task automatic step(input bit st, input logic [31:0] a, input logic [127:0] d, input bit g);
    bit pop, rdy;
    logic [127:0] tmp;
    chk("fill", fill_o, m_fill);
    chk("busy", busy_o, m_wl > 0);
    chk("write_en", write_en_out, m_wl > 0);
    chk("overflow", overflow_o, m_ovf);
    start_aes_wb = st; address_in = a; data_in = d; write_gnt_i = g;
    #1;
    pop = (m_fill > 0) && ((m_wl == 0) || (m_wl == 1 && g));
    rdy = (m_fill < DEPTH) || pop;
    chk("in_ready", in_ready_o, rdy);
    chk("halt", halt_en_out, (m_wl > 0) || (m_fill > 0) || st);
    if (m_wl > 0) begin
      if (exp_addr.size() == 0) begin
        chk("model_empty", 1'b1, 1'b0);
      end else begin
        chk("address", address_out, exp_addr[0]);
        chk("data", data_out, exp_data[0]);
        if (g) begin
          void'(exp_addr.pop_front());
          void'(exp_data.pop_front());
          n_writes++;
        end
      end
      if (g) m_wl--;
    end
    if (st && rdy) begin
      for (int k = 0; k < NW; k++) begin
        tmp = d >> ((NW - 1 - k) * 32);
        exp_addr.push_back(a + 32'(k * 4));
        exp_data.push_back(tmp[31:0]);
      end
    end
    if (st && !rdy) m_ovf = 1'b1;
    if (pop) m_wl = NW;
    m_fill = m_fill + ((st && rdy) ? 1 : 0) - (pop ? 1 : 0);
    @(negedge clk);
  endtask

  task automatic drain(input int max_cycles);
    int c = 0;
    while ((m_wl > 0 || m_fill > 0) && c < max_cycles) begin
      step(1'b0, 32'h0, 128'h0, 1'b1);
      c++;
    end
    if (m_wl > 0 || m_fill > 0) chk("drain_timeout", 1'b0, 1'b1);
    step(1'b0, 32'h0, 128'h0, 1'b1);
  endtask

  initial begin
    logic [127:0] blk;
    int w0;
    blk = 128'hdeadbeef_deafbabe_cafeface_01234567;
    rst_n = 1'b0; start_aes_wb = 1'b0; address_in = '0; data_in = '0; write_gnt_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_write_en", write_en_out, 1'b0);
    chk("rst_addr", address_out, 32'h0);
    chk("rst_data", data_out, 32'h0);
    chk("rst_halt", halt_en_out, 1'b0);
    chk("rst_in_ready", in_ready_o, 1'b1);
    chk("rst_fill", fill_o, 3'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single block, grant high
    w0 = n_writes;
    step(1'b1, 32'h1000, blk, 1'b1);
    drain(20);
    chk("single_writes", n_writes - w0, 4);

    // backpressure: grant every third cycle
    w0 = n_writes;
    step(1'b1, 32'h1000, blk, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b0, 32'h0, 128'h0, (i % 3) == 2);
    drain(20);
    chk("bp_writes", n_writes - w0, 4);

    // back-to-back blocks
    w0 = n_writes;
    step(1'b1, 32'h2000, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    step(1'b1, 32'h3000, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    drain(30);
    chk("b2b_writes", n_writes - w0, 8);

    // address wrap
    step(1'b1, 32'hFFFF_FFF8, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    drain(20);

    // random traffic
    for (int i = 0; i < 600; i++)
      step(($urandom % 4) == 0, $urandom, {$urandom, $urandom, $urandom, $urandom}, ($urandom % 3) != 0);
    drain(100);

    // overflow: six pushes with grant held low
    w0 = n_writes;
    for (int i = 0; i < 6; i++)
      step(1'b1, 32'h4000 + 32'(i * 16), {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    step(1'b0, 32'h0, 128'h0, 1'b0);
    chk("ovf_fill", fill_o, 3'd4);
    chk("ovf_flag", overflow_o, 1'b1);
    drain(60);
    chk("ovf_writes", n_writes - w0, 20);
    chk("ovf_sticky", overflow_o, 1'b1);

    // reset after two of four grants
    w0 = n_writes;
    step(1'b1, 32'h5000, blk, 1'b0);
    step(1'b0, 32'h0, 128'h0, 1'b0);
    step(1'b0, 32'h0, 128'h0, 1'b1);
    step(1'b0, 32'h0, 128'h0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_write_en", write_en_out, 1'b0);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_addr", address_out, 32'h0);
    chk("mid_rst_data", data_out, 32'h0);
    chk("mid_rst_ovf", overflow_o, 1'b0);
    chk("mid_rst_fill", fill_o, 3'd0);
    chk("mid_rst_in_ready", in_ready_o, 1'b1);
    chk("mid_rst_halt", halt_en_out, 1'b0);
    m_fill = 0; m_wl = 0; m_ovf = 1'b0;
    exp_addr.delete(); exp_data.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 128'h0, 1'b1);
    chk("mid_rst_writes", n_writes - w0, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
